// File: rtl/mult_pkg.sv
// Shared definitions for the tiled Wallace multiplier.
// The FIX state only exists when SIGNED_MODE_EN is defined.
package mult_pkg;

  localparam int TILE_W  = 8;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef SIGNED_MODE_EN
    ST_FIX  = 2'd2,
`endif
    ST_DONE = 2'd3
  } st_e;

  // Number of byte tiles in an operand of width w.
  function automatic int tile_count(input int w);
    return w / TILE_W;
  endfunction

endpackage

// File: rtl/wallace_tiled_mult_tile_mul8.sv
// tile_mul8: combinational 8x8 unsigned Wallace-tree multiplier.
// Partial-product bits are kept as per-column bit bags; every stage feeds
// groups of three through full adders and a leftover pair through a half
// adder, until each column holds at most two bits. A final adder sums the
// two remaining rows. Column heights do not depend on data, so the loops
// unroll into a fixed adder network.
module tile_mul8 (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);

  localparam int COLS   = 16;
  localparam int MAXH   = 16;
  localparam int STAGES = 6;
  localparam int GROUPS = 5;

  // Partial products, Wallace column reduction, and the final two-row add.
  always_comb begin : wallace
    logic [MAXH-1:0] cur [COLS+1];
    logic [MAXH-1:0] nxt [COLS+1];
    int              h   [COLS+1];
    int              nh  [COLS+1];
    logic [COLS-1:0] row0;
    logic [COLS-1:0] row1;
    logic            busy;
    int              k;
    logic            x0;
    logic            x1;
    logic            x2;

    for (int c = 0; c <= COLS; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      h[c]   = 0;
      nh[c]  = 0;
    end
    busy = 1'b0;
    k    = 0;
    x0   = 1'b0;
    x1   = 1'b0;
    x2   = 1'b0;
    row0 = '0;
    row1 = '0;

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cur[r+c][h[r+c]] = x[c] & y[r];
        h[r+c]           = h[r+c] + 1;
      end
    end

    for (int s = 0; s < STAGES; s++) begin
      busy = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        busy = busy | (h[c] > 2);
      end
      for (int c = 0; c <= COLS; c++) begin
        nxt[c] = '0;
        nh[c]  = 0;
      end
      if (busy) begin
        for (int c = 0; c < COLS; c++) begin
          for (int g = 0; g < GROUPS; g++) begin
            k  = 3 * g;
            x0 = cur[c][k];
            x1 = cur[c][k+1];
            x2 = cur[c][k+2];
            if (k + 2 < h[c]) begin
              nxt[c][nh[c]]     = x0 ^ x1 ^ x2;
              nh[c]             = nh[c] + 1;
              nxt[c+1][nh[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
              nh[c+1]           = nh[c+1] + 1;
            end else if (k + 1 < h[c]) begin
              nxt[c][nh[c]]     = x0 ^ x1;
              nh[c]             = nh[c] + 1;
              nxt[c+1][nh[c+1]] = x0 & x1;
              nh[c+1]           = nh[c+1] + 1;
            end else if (k < h[c]) begin
              nxt[c][nh[c]] = x0;
              nh[c]         = nh[c] + 1;
            end else begin
              nh[c] = nh[c];
            end
          end
        end
        for (int c = 0; c <= COLS; c++) begin
          cur[c] = nxt[c];
          h[c]   = nh[c];
        end
      end else begin
        busy = 1'b0;
      end
    end

    // Entries above a column's height are always zero.
    for (int c = 0; c < COLS; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
    p = row0 + row1;
  end

endmodule

// File: rtl/wallace_tiled_mult.sv
// wallace_tiled_mult: sequential WIDTHxWIDTH multiplier built from one shared
// 8x8 Wallace tile. One tile product per MUL cycle (a tile outer, b tile
// inner) is shifted into a 2*WIDTH accumulator; the result is held in DONE
// until the consumer takes it.
// Optional build macro SIGNED_MODE_EN adds the sgn port and the FIX state,
// which negates the magnitude product when the operand signs differ.
module wallace_tiled_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = tile_count(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (((WIDTH % TILE_W) != 0) || (WIDTH < TILE_W)) begin : g_bad_width
    $error("wallace_tiled_mult: WIDTH must be a multiple of 8 and at least 8");
  end

  st_e             state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    product_q, product_d;
`ifdef SIGNED_MODE_EN
  logic             neg_q, neg_d;
`endif

  logic [TILE_W-1:0]   tile_a;
  logic [TILE_W-1:0]   tile_b;
  logic [2*TILE_W-1:0] tile_prod;
  logic [PW-1:0]       shifted;
  logic [PW-1:0]       acc_sum;
  logic                last_tile;
  logic                last_j;

`ifdef SIGNED_MODE_EN
  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    logic [WIDTH-1:0] r;
    if (is_signed && v[WIDTH-1]) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  tile_mul8 u_tile (
    .x (tile_a),
    .y (tile_b),
    .p (tile_prod)
  );

  // Select the current tile pair and add its weighted product to the accumulator.
  always_comb begin
    tile_a    = a_q[int'(i_q) * TILE_W +: TILE_W];
    tile_b    = b_q[int'(j_q) * TILE_W +: TILE_W];
    shifted   = PW'(tile_prod) << (TILE_W * (int'(i_q) + int'(j_q)));
    acc_sum   = acc_q + shifted;
    last_j    = (j_q == CW'(N - 1));
    last_tile = last_j && (i_q == CW'(N - 1));
  end

  // Next-state and next-output logic for the IDLE/MUL/(FIX)/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
`ifdef SIGNED_MODE_EN
    neg_d       = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        product_d   = '0;
        if (in_valid) begin
`ifdef SIGNED_MODE_EN
          a_d   = magnitude(a, sgn);
          b_d   = magnitude(b, sgn);
          neg_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
          a_d   = a;
          b_d   = b;
`endif
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          in_ready_d = 1'b0;
          state_d    = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = acc_sum;
        if (last_tile) begin
          i_d = '0;
          j_d = '0;
`ifdef SIGNED_MODE_EN
          state_d = ST_FIX;
`else
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          product_d   = acc_sum;
`endif
        end else if (last_j) begin
          j_d = '0;
          i_d = i_q + CW'(1);
        end else begin
          j_d = j_q + CW'(1);
        end
      end
`ifdef SIGNED_MODE_EN
      ST_FIX: begin
        if (neg_q) begin
          product_d = ~acc_q + PW'(1);
        end else begin
          product_d = acc_q;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          product_d   = '0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        product_d   = '0;
      end
    endcase
  end

  // State and registered outputs; rst wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
`ifdef SIGNED_MODE_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
`ifdef SIGNED_MODE_EN
      neg_q       <= neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
